// File: rtl/score_display.sv
// Score overlay: converts the binary score to BCD with a serial shift-add-3 sequencer,
// draws five 7-segment digits and a blinking win/lose banner as a registered rgb overlay.
module score_display #(
    parameter logic [9:0]  DIGIT_X      = 10'd480,
    parameter logic [9:0]  DIGIT_Y      = 10'd40,
    parameter logic [9:0]  DIGIT_PITCH  = 10'd20,
    parameter logic [9:0]  BANNER_X0    = 10'd200,
    parameter logic [9:0]  BANNER_X1    = 10'd440,
    parameter logic [9:0]  BANNER_Y0    = 10'd220,
    parameter logic [9:0]  BANNER_Y1    = 10'd260,
    parameter logic [5:0]  BLINK_FRAMES = 6'd30,
    parameter logic [11:0] DIGIT_RGB    = 12'hFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic [15:0] score,
    input  logic        winIn,
    input  logic        loseIn,
    output logic [11:0] rgb,
    output logic        overlayFill,
    output logic [19:0] bcdDigits,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} conv_state_t;

    conv_state_t state_q;
    logic [15:0] shift_q;
    logic [19:0] bcd_work_q;
    logic [4:0]  iter_q;
    logic [15:0] last_score_q;
    logic [19:0] pending_q;
    logic [19:0] bcd_digits_q;
    logic        busy_q;

    logic [5:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [11:0] rgb_q, rgb_d;
    logic        fill_q, fill_d;

    logic        frame_start;
    logic [19:0] bcd_adj;
    logic [35:0] shifted;
    logic [4:0]  digit_lit;
    logic [4:0]  digit_show;
    logic        in_banner;

    assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Which segment rectangles (a..g, MSB first) cover a cell-local pixel.
    function automatic logic [6:0] seg_cover(input logic [9:0] cx, input logic [9:0] cy);
        logic mid_x, left_x, right_x, top_y, bot_y;
        mid_x   = (cx >= 10'd3)  && (cx <= 10'd12);
        left_x  = (cx <= 10'd2);
        right_x = (cx >= 10'd13) && (cx <= 10'd15);
        top_y   = (cy >= 10'd3)  && (cy <= 10'd11);
        bot_y   = (cy >= 10'd12) && (cy <= 10'd20);
        return {mid_x && (cy <= 10'd2),
                right_x && top_y,
                right_x && bot_y,
                mid_x && (cy >= 10'd21) && (cy <= 10'd23),
                left_x && bot_y,
                left_x && top_y,
                mid_x && (cy >= 10'd11) && (cy <= 10'd13)};
    endfunction

    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_work_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_work_q[gi*4 +: 4] + 4'd3 : bcd_work_q[gi*4 +: 4];
    end

    assign shifted = {bcd_adj, shift_q} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bcd_work_q   <= '0;
            iter_q       <= '0;
            last_score_q <= '0;
            pending_q    <= '0;
            bcd_digits_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (score != last_score_q) begin
                        shift_q      <= score;
                        last_score_q <= score;
                        bcd_work_q   <= '0;
                        iter_q       <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_work_q <= shifted[35:16];
                    shift_q    <= shifted[15:0];
                    iter_q     <= iter_q + 5'd1;
                    if (iter_q == 5'd15) begin
                        pending_q <= shifted[35:16];
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    // Commit only at the top of a frame so digits never tear mid-frame.
                    if (frame_start) begin
                        bcd_digits_q <= pending_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!(winIn || loseIn)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_FRAMES - 6'd1) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 6'd1;
            end
        end
    end

    // Cell gi = 0 is the ones digit, drawn rightmost.
    for (genvar gi = 0; gi < 5; gi++) begin : g_digit
        localparam logic [9:0] CELL_X = DIGIT_X + DIGIT_PITCH * 10'(4 - gi);
        logic [9:0] cx;
        logic [9:0] cy;
        logic       in_cell;

        assign cx      = hCount - CELL_X;
        assign cy      = vCount - DIGIT_Y;
        assign in_cell = (hCount >= CELL_X) && (cx < 10'd16) &&
                         (vCount >= DIGIT_Y) && (cy < 10'd24);

        if (gi == 0) begin : g_ones
            assign digit_show[gi] = 1'b1;
        end else begin : g_upper
            assign digit_show[gi] = |bcd_digits_q[19:gi*4];
        end

        assign digit_lit[gi] = in_cell && digit_show[gi] &&
                               (|(seg_decode(bcd_digits_q[gi*4 +: 4]) & seg_cover(cx, cy)));
    end

    assign in_banner = (hCount >= BANNER_X0) && (hCount <= BANNER_X1) &&
                       (vCount >= BANNER_Y0) && (vCount <= BANNER_Y1);

    always_comb begin
        rgb_d  = '0;
        fill_d = 1'b0;
        if (bright) begin
            if ((winIn || loseIn) && blink_phase_q && in_banner) begin
                fill_d = 1'b1;
                rgb_d  = winIn ? 12'h0F0 : 12'hF00;
            end else if (|digit_lit) begin
                fill_d = 1'b1;
                rgb_d  = DIGIT_RGB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            rgb_q         <= '0;
            fill_q        <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            rgb_q         <= rgb_d;
            fill_q        <= fill_d;
        end
    end

    assign rgb         = rgb_q;
    assign overlayFill = fill_q;
    assign bcdDigits   = bcd_digits_q;
    assign busy        = busy_q;

endmodule
